muskbus_mem_responder: RTL and testbench
========================================

Name: muskbus_mem_responder

Overview:
- Memory-side (responder) end of the Muskbus. It answers line-granular read and write requests from the core-side bus mux and caches.
- Backed by an internal word array. Returns 64-byte lines as 8 beats of 64 bits.
- Used as the simulation memory model and as the bus target for cache and fetch-path verification.

Parameters:
- MEM_WORDS, 4096: backing store depth in 64-bit words; power of two.
- READ_LATENCY, 4: idle cycles between read acceptance and the first response beat; 0 is legal.
- BEATS, 8: beats per line; fixed at 8 for 64-byte lines.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- reqcyc  in  1  request/data beat valid
- req  in  64  request address on the first beat; write data on later beats
- reqtag  in  13  bit12 = 1 write / 0 read; bits[11:0] opaque id
- reqack  out  1  request or write beat accepted this cycle
- respcyc  out  1  response beat valid
- resp  out  64  response data
- resptag  out  13  tag echoed from the accepted request
- respack  in  1  requester consumed the current response beat

Behaviour:
- States: IDLE, WR_DATA, RD_WAIT, RD_BEAT. Reset sets state IDLE, beat counter 0, latency counter 0, respcyc 0, resp 0, resptag 0.
- reqack is combinational: reqcyc && (state==IDLE || state==WR_DATA) && !reset. It is never asserted in RD_WAIT or RD_BEAT; the requester holds req stable until acked.
- IDLE, on reqcyc:
  - Latch line index = req[63:6] mod (MEM_WORDS/8). The low 6 address bits are ignored, so requests are line-aligned.
  - Latch reqtag and clear the beat counter.
  - If reqtag[12]=1, go to WR_DATA.
  - If reqtag[12]=0, go to RD_WAIT with latency counter = READ_LATENCY; if READ_LATENCY=0, go directly to RD_BEAT.
- WR_DATA:
  - Each cycle with reqcyc writes req to word (line*8 + beat) and increments beat.
  - Cycles with reqcyc=0 are bubbles: no write, no ack.
  - After beat 7 is written, return to IDLE. No response is issued (see Optional Feature).
- RD_WAIT: decrement the counter each cycle; enter RD_BEAT in the cycle after the counter reaches 1. First respcyc appears exactly READ_LATENCY+1 cycles after the reqack cycle.
- RD_BEAT:
  - respcyc=1, resp=mem[line*8+beat], resptag=latched tag. Outputs are registered.
  - When respack=1, advance to the next beat; the next beat's data is presented in the following cycle.
  - When respack=0, hold resp and resptag unchanged.
  - Beat order is ascending address: beat 0 = lowest word.
  - After beat 7 is acked, respcyc=0 in the next cycle and state returns to IDLE. A new request is accepted no earlier than that IDLE cycle, so there is at least one bubble between transactions.
- Only one transaction is outstanding at a time. No pipelining of a new request with in-flight responses.
- Reset mid-transaction aborts it: state IDLE, respcyc 0. Memory contents are preserved; a partial write keeps the beats already written.
- Memory is not cleared by reset. Initial contents are X unless preloaded by the bench through hierarchical access.
- Address wrap: a line index at or beyond MEM_WORDS/8 aliases modulo, with no error.

Optional Feature:
- Macro: MUSKBUS_WRITE_RESP_EN.
- Defined: after the 8th write beat, enter state WR_RESP. Drive one beat with respcyc=1, resp=64'h0, resptag=latched tag, held until respack, then return to IDLE.
- Undefined: the WR_RESP state is not compiled, and writes return to IDLE silently after beat 7.

Test Plan:
- Write line 0x1000 (tag 0x1005, data 0x11..0x88), then read 0x1000 with tag 0x0007 and respack held 1 -> 8 beats 0x11..0x88, resptag 0x0007 on every beat, first beat READ_LATENCY+1 cycles after reqack.
- Read with respack low for 3 cycles on beat 2 -> resp holds the beat-2 word for all 3 cycles, and beat 3 appears the cycle after respack=1.
- Write with reqcyc bubbles between beats 3 and 4 -> no reqack during bubbles; readback shows all 8 words intact.
- Reset asserted while on beat 4 of a read -> respcyc=0 the next cycle; a fresh read of the same line returns all 8 correct words starting at beat 0.
- MEM_WORDS=4096: write to address 0x8000 (line 512), read back at 0x0 -> same data (alias). Address 0x103F reads line 0x1000.
- MUSKBUS_WRITE_RESP_EN defined: write with tag 0x1ABC -> one respcyc beat with resp=0 and resptag 0x1ABC after beat 7. With the macro undefined, respcyc stays 0.

Source files
------------

// File: rtl/muskbus_mem_responder_if.sv
// Muskbus request/response bundle between a core-side requester (master) and a
// memory responder (slave).
interface muskbus_mem_responder_if;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/muskbus_mem_responder.sv
// Muskbus memory responder: line-granular (8 x 64-bit) reads/writes to an internal array.
// Optional MUSKBUS_WRITE_RESP_EN adds a single zero-data response beat after each write.
module muskbus_mem_responder #(
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4,
    parameter int BEATS        = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    muskbus_mem_responder_if.slave        bus
);
    localparam int LINES  = MEM_WORDS / BEATS;
    localparam int LINE_W = $clog2(LINES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int ADDR_W = LINE_W + BEAT_W;
    localparam int LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_WAIT,
        RD_BEAT
`ifdef MUSKBUS_WRITE_RESP_EN
        ,WR_RESP
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [12:0]         tag_q, tag_d;
    logic                respcyc_q, respcyc_d;
    logic [63:0]         resp_q, resp_d;
    logic [12:0]         resptag_q, resptag_d;

    logic                accept;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [LINE_W-1:0]   req_line;
    logic [63:0]         mem_q [MEM_WORDS];

    // Byte offset is 6 bits (8 beats x 8 bytes); taking only LINE_W bits above it
    // gives the modulo aliasing for out-of-range line indices.
    assign req_line  = bus.req[6 +: LINE_W];
    assign beat_nxt  = beat_q + 1'b1;
    assign mem_waddr = {line_q, beat_q};

    assign accept     = bus.reqcyc && !reset && (state_q == IDLE || state_q == WR_DATA);
    assign bus.reqack = accept;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        line_d    = line_q;
        tag_d     = tag_q;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    line_d = req_line;
                    tag_d  = bus.reqtag;
                    beat_d = '0;
                    if (bus.reqtag[12]) begin
                        state_d = WR_DATA;
                    end else if (READ_LATENCY == 0) begin
                        state_d   = RD_BEAT;
                        respcyc_d = 1'b1;
                        resp_d    = mem_q[{req_line, {BEAT_W{1'b0}}}];
                        resptag_d = bus.reqtag;
                    end else begin
                        state_d = RD_WAIT;
                        lat_d   = LAT_W'(READ_LATENCY);
                    end
                end
            end

            WR_DATA: begin
                if (accept) begin
                    mem_we = 1'b1;
                    beat_d = beat_nxt;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
`ifdef MUSKBUS_WRITE_RESP_EN
                        state_d   = WR_RESP;
                        respcyc_d = 1'b1;
                        resp_d    = '0;
                        resptag_d = tag_q;
`else
                        state_d   = IDLE;
`endif
                    end
                end
            end

            RD_WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == LAT_W'(1)) begin
                    state_d   = RD_BEAT;
                    respcyc_d = 1'b1;
                    resp_d    = mem_q[{line_q, beat_q}];
                    resptag_d = tag_q;
                end
            end

            RD_BEAT: begin
                if (bus.respack) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                    end else begin
                        beat_d = beat_nxt;
                        resp_d = mem_q[{line_q, beat_nxt}];
                    end
                end
            end

`ifdef MUSKBUS_WRITE_RESP_EN
            WR_RESP: begin
                if (bus.respack) begin
                    state_d   = IDLE;
                    respcyc_d = 1'b0;
                end
            end
`endif

            default: begin
                state_d   = IDLE;
                respcyc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // Line index and tag are pure data: only meaningful once a request is accepted.
    always_ff @(posedge clk) begin
        line_q <= line_d;
        tag_q  <= tag_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= bus.req;
        end
    end

    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;

endmodule

// File: tb/tb_muskbus_mem_responder.sv
// Directed-plus-random bench for muskbus_mem_responder against a flat word-array model.
module tb_muskbus_mem_responder;
    localparam int MEM_WORDS    = 4096;
    localparam int READ_LATENCY = 4;
    localparam int BEATS        = 8;
    localparam int LINES        = MEM_WORDS / BEATS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [63:0] model [MEM_WORDS];
    logic [63:0] wdata [BEATS];

    muskbus_mem_responder_if bus();

    muskbus_mem_responder #(
        .MEM_WORDS   (MEM_WORDS),
        .READ_LATENCY(READ_LATENCY),
        .BEATS       (BEATS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int word_idx(input logic [63:0] addr, input int b);
        return int'((addr >> 6) % 64'(LINES)) * BEATS + b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < BEATS; b++) wdata[b] = {$urandom, $urandom};
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic req_beat(input logic [63:0] d, input logic [12:0] t, output int acc_cyc);
        int n;
        n = 0;
        bus.reqcyc = 1'b1;
        bus.req    = d;
        bus.reqtag = t;
        #1;
        while (bus.reqack !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reqack_wait", 64'(n < 40), 64'(1));
        acc_cyc = cyc;
        @(negedge clk);
        bus.reqcyc = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                            input int bub_after, input int nbub, input int abort_at);
        int ac;
        req_beat(addr, tag, ac);
        for (int b = 0; b < BEATS; b++) begin
            if (b == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("wr_abort_respcyc", 64'(bus.respcyc), 64'(0));
                return;
            end
            req_beat(wdata[b], tag, ac);
            model[word_idx(addr, b)] = wdata[b];
            if (b < BEATS - 1) chk("wr_no_resp_mid", 64'(bus.respcyc), 64'(0));
            if (b == bub_after) begin
                repeat (nbub) begin
                    #1;
                    chk("wr_bubble_noack", 64'(bus.reqack), 64'(0));
                    @(negedge clk);
                end
            end
        end
`ifdef MUSKBUS_WRITE_RESP_EN
        chk("wr_resp_cyc", 64'(bus.respcyc), 64'(1));
        chk("wr_resp_data", bus.resp, 64'(0));
        chk("wr_resp_tag", 64'(bus.resptag), 64'(tag));
        bus.respack = 1'b0;
        @(negedge clk);
        chk("wr_resp_hold", 64'(bus.respcyc), 64'(1));
        bus.respack = 1'b1;
        @(negedge clk);
        bus.respack = 1'b0;
        chk("wr_resp_done", 64'(bus.respcyc), 64'(0));
`else
        repeat (2) begin
            chk("wr_no_resp_after", 64'(bus.respcyc), 64'(0));
            @(negedge clk);
        end
`endif
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input bit early_ack,
                           input int stall_beat, input int stall_n, input int abort_at);
        int ac;
        int n;
        logic [63:0] exp;
        bus.respack = early_ack;
        req_beat(addr, tag, ac);
        n = 0;
        while (bus.respcyc !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rd_latency", 64'(cyc - ac), 64'(READ_LATENCY + 1));
        for (int b = 0; b < BEATS; b++) begin
            exp = model[word_idx(addr, b)];
            chk("rd_cyc", 64'(bus.respcyc), 64'(1));
            chk("rd_data", bus.resp, exp);
            chk("rd_tag", 64'(bus.resptag), 64'(tag));
            if (b == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                bus.respack = 1'b0;
                chk("rd_abort_respcyc", 64'(bus.respcyc), 64'(0));
                chk("rd_abort_resp", bus.resp, 64'(0));
                chk("rd_abort_tag", 64'(bus.resptag), 64'(0));
                return;
            end
            if (b == stall_beat) begin
                bus.respack = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("rd_hold_cyc", 64'(bus.respcyc), 64'(1));
                    chk("rd_hold_data", bus.resp, exp);
                    chk("rd_hold_tag", 64'(bus.resptag), 64'(tag));
                    if (s == 0) begin
                        bus.reqcyc = 1'b1;
                        #1;
                        chk("rd_busy_noack", 64'(bus.reqack), 64'(0));
                        bus.reqcyc = 1'b0;
                    end
                end
            end
            bus.respack = 1'b1;
            @(negedge clk);
        end
        bus.respack = 1'b0;
        chk("rd_end_respcyc", 64'(bus.respcyc), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] addr;
        logic [12:0] tg;
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state; reqack must stay low while reset is high
        bus.reqcyc = 1'b1;
        bus.reqtag = 13'h0001;
        #1;
        chk("rst_reqack", 64'(bus.reqack), 64'(0));
        chk("rst_respcyc", 64'(bus.respcyc), 64'(0));
        chk("rst_resp", bus.resp, 64'(0));
        chk("rst_resptag", 64'(bus.resptag), 64'(0));
        bus.reqcyc = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Known pattern write then back-to-back read
        for (int b = 0; b < BEATS; b++) wdata[b] = 64'h11 * 64'(b + 1);
        do_write(64'h1000, 13'h1005, BEATS, 0, BEATS);
        do_read(64'h1000, 13'h0007, 1'b1, BEATS, 0, BEATS);

        // Stall on beat 2 for three cycles
        do_read(64'h1000, 13'h0123, 1'b0, 2, 3, BEATS);

        // Write with bubbles between beats 3 and 4
        fill_random();
        do_write(64'h2040, 13'h1010, 3, 3, BEATS);
        do_read(64'h2040, 13'h0044, 1'b1, BEATS, 0, BEATS);

        // Reset on beat 4 of a read, then a fresh full read
        do_read(64'h2040, 13'h0055, 1'b1, BEATS, 0, 4);
        @(negedge clk);
        do_read(64'h2040, 13'h0056, 1'b0, 5, 2, BEATS);

        // Aliasing: line 512 maps onto line 0; low six address bits ignored
        fill_random();
        do_write(64'h8000, 13'h1ABC, BEATS, 0, BEATS);
        do_read(64'h0, 13'h0ABC, 1'b1, BEATS, 0, BEATS);
        do_read(64'h103F, 13'h0FFF, 1'b1, 0, 1, BEATS);

        // Partial write aborted by reset keeps the beats already written
        fill_random();
        do_write(64'h1000, 13'h1111, BEATS, 0, 3);
        @(negedge clk);
        do_read(64'h1000, 13'h0111, 1'b1, BEATS, 0, BEATS);

        // Random traffic across the full address space
        for (int i = 0; i < 10; i++) begin
            addr = {$urandom, $urandom};
            tg   = 13'($urandom) | 13'h1000;
            fill_random();
            do_write(addr, tg, int'($urandom_range(0, BEATS)), int'($urandom_range(1, 3)), BEATS);
            addr = addr ^ 64'($urandom_range(0, 63));
            tg   = 13'($urandom) & 13'h0FFF;
            do_read(addr, tg, 1'($urandom), int'($urandom_range(0, BEATS)),
                    int'($urandom_range(1, 4)), BEATS);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
